// File: rtl/mnist_stream_checker.sv
// Streams IMAGE_COUNT images from a sync ROM into the MNIST core byte-serially and
// scores each predicted class against the cyclic label order of the test set.
module mnist_stream_checker #(
    parameter int IMAGE_COUNT     = 480,
    parameter int BYTES_PER_IMAGE = 32,
    parameter int NUM_CLASSES     = 10,
    parameter int RESULT_LATENCY  = 2,
    parameter int ADDR_W          = 16,
    localparam int CW             = $clog2(IMAGE_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              stop_on_fail,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        dut_data,
    output logic              dut_valid,
    output logic              dut_first,
    input  logic [3:0]        dut_index,
    input  logic [7:0]        dut_value,
    output logic [3:0]        result_index,
    output logic [7:0]        result_value,
    output logic [3:0]        expected,
    output logic [CW-1:0]     pass_count,
    output logic [CW-1:0]     fail_count,
    output logic [CW-1:0]     first_fail,
    output logic              failed,
    output logic              busy,
    output logic              done
);

    localparam int BW = (BYTES_PER_IMAGE > 1) ? $clog2(BYTES_PER_IMAGE) : 1;
    localparam int LW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam logic [BW-1:0]     LAST_BYTE     = BW'(BYTES_PER_IMAGE - 1);
    localparam logic [LW-1:0]     LAST_LAT      = LW'(RESULT_LATENCY - 1);
    localparam logic [CW-1:0]     LAST_IMG      = CW'(IMAGE_COUNT - 1);
    localparam logic [3:0]        LAST_LABEL    = 4'(NUM_CLASSES - 1);
    localparam logic [4:0]        NUM_CLASSES_5 = 5'(NUM_CLASSES);
    localparam logic [ADDR_W-1:0] IMG_STRIDE    = ADDR_W'(BYTES_PER_IMAGE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_CHECK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_addr;
    logic [BW-1:0]     byte_idx;
    logic [LW-1:0]     lat_cnt;
    logic [CW-1:0]     img;
    logic              stop_latched;
    logic              mismatch;
    logic              run_end;

    // Out-of-range class indices are mismatches even if a label ever aliased them
    assign mismatch = (dut_index != expected) || ({1'b0, dut_index} >= NUM_CLASSES_5);
    assign run_end  = (img == LAST_IMG) || (mismatch && stop_latched);

    assign rom_addr = base_addr + ADDR_W'(byte_idx);
    assign dut_data = rom_data;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start)                 state_next = S_FEED;
            S_FEED:         if (byte_idx == LAST_BYTE) state_next = S_DRAIN;
            S_DRAIN:        if (lat_cnt == LAST_LAT)   state_next = S_CHECK;
            S_CHECK:        state_next = run_end ? S_DONE : S_WAIT;
            S_WAIT:         if (step)                  state_next = S_FEED;
            default:        state_next = S_IDLE;
        endcase
    end

    // Valid/first are delayed one cycle so they line up with the ROM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_valid    <= 1'b0;
            dut_first    <= 1'b0;
            base_addr    <= '0;
            byte_idx     <= '0;
            lat_cnt      <= '0;
            img          <= '0;
            expected     <= '0;
            stop_latched <= 1'b0;
            result_index <= '0;
            result_value <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
            first_fail   <= '0;
            failed       <= 1'b0;
        end else begin
            dut_valid <= (state == S_FEED);
            dut_first <= (state == S_FEED) && (byte_idx == '0);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_addr    <= '0;
                        byte_idx     <= '0;
                        img          <= '0;
                        expected     <= '0;
                        stop_latched <= stop_on_fail;
                        result_index <= '0;
                        result_value <= '0;
                        pass_count   <= '0;
                        fail_count   <= '0;
                        first_fail   <= '0;
                        failed       <= 1'b0;
                    end
                end
                S_FEED: begin
                    lat_cnt  <= '0;
                    byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 1'b1;
                end
                S_DRAIN: lat_cnt <= lat_cnt + 1'b1;
                S_CHECK: begin
                    result_index <= dut_index;
                    result_value <= dut_value;
                    if (mismatch) begin
                        fail_count <= fail_count + 1'b1;
                        if (!failed) first_fail <= img;
                        failed <= 1'b1;
                    end else begin
                        pass_count <= pass_count + 1'b1;
                    end
                    // Base address and label advance as running counters
                    if (!run_end) begin
                        img       <= img + 1'b1;
                        base_addr <= base_addr + IMG_STRIDE;
                        expected  <= (expected == LAST_LABEL) ? 4'd0 : expected + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_stream_checker.sv
// Randomized bench for mnist_stream_checker: an emulated core answers only in the exact
// result cycle, and a per-run reference model predicts the counters and stream.
module tb_mnist_stream_checker;

    localparam int IC  = 12;
    localparam int BPI = 4;
    localparam int NC  = 10;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step;
    logic        stop_on_fail;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  dut_data;
    logic        dut_valid;
    logic        dut_first;
    logic [3:0]  dut_index;
    logic [7:0]  dut_value;
    logic [3:0]  result_index;
    logic [7:0]  result_value;
    logic [3:0]  expected;
    logic [3:0]  pass_count;
    logic [3:0]  fail_count;
    logic [3:0]  first_fail;
    logic        failed;
    logic        busy;
    logic        done;

    int nChecks = 0;
    int nFails  = 0;

    mnist_stream_checker #(
        .IMAGE_COUNT(IC),
        .BYTES_PER_IMAGE(BPI),
        .NUM_CLASSES(NC),
        .RESULT_LATENCY(LAT),
        .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .step(step),
        .stop_on_fail(stop_on_fail),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .dut_data(dut_data),
        .dut_valid(dut_valid),
        .dut_first(dut_first),
        .dut_index(dut_index),
        .dut_value(dut_value),
        .result_index(result_index),
        .result_value(result_value),
        .expected(expected),
        .pass_count(pass_count),
        .fail_count(fail_count),
        .first_fail(first_fail),
        .failed(failed),
        .busy(busy),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sync ROM whose contents equal the low address byte
    always @(posedge clk) rom_data <= rom_addr[7:0];

    task automatic checkOutput(input string tag, input int observed, input int wanted);
        nChecks++;
        if (observed != wanted) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, wanted);
        end
    endtask

    function automatic logic [3:0] labelOf(input int img);
        return 4'(img % NC);
    endfunction

    function automatic logic [3:0] wrongIdx(input int img);
        return labelOf(img) ^ 4'(1 + (img * 5) % 15);
    endfunction

    function automatic logic [7:0] scoreOf(input int img);
        return 8'(img * 13 + 5);
    endfunction

    task automatic checkResetState();
        checkOutput("rst_pass", int'(pass_count), 0);
        checkOutput("rst_fail", int'(fail_count), 0);
        checkOutput("rst_failed", int'(failed), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_addr", int'(rom_addr), 0);
        checkOutput("rst_valid", int'(dut_valid), 0);
        checkOutput("rst_expected", int'(expected), 0);
        checkOutput("rst_result", int'(result_index), 0);
    endtask

    // pacing: 0 = step tied high, 1 = random step, 2 = step pulse every 20 cycles
    task automatic applyStimulus(input bit stopMode, input int pacing, input logic [IC-1:0] wrongMask,
                                 input bit midStart, input int resetAt);
        int nExp, passExp, failExp, firstExp, cyc, streamPos, sinceLast, lastStep, img;
        bit failedExp, aborted;
        logic [3:0] lab;

        nExp = 0; passExp = 0; failExp = 0; firstExp = 0; failedExp = 1'b0;
        for (int i = 0; i < IC; i++) begin
            nExp = i + 1;
            if (wrongMask[i]) begin
                if (!failedExp) firstExp = i;
                failedExp = 1'b1;
                failExp++;
                if (stopMode) break;
            end else begin
                passExp++;
            end
        end

        @(negedge clk);
        stop_on_fail = stopMode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop_on_fail = 1'($urandom_range(0, 1));

        streamPos = 0; sinceLast = -1; lastStep = -100; aborted = 1'b0; cyc = 0;
        while (!done && cyc < 3000) begin
            if (dut_valid) begin
                checkOutput("byte", int'(dut_data), streamPos % 256);
                checkOutput("first", int'(dut_first), int'(streamPos % BPI == 0));
                if (streamPos % BPI == 0) begin
                    img = streamPos / BPI;
                    checkOutput("label", int'(expected), img % NC);
                    if (pacing == 2 && img > 0) checkOutput("pace", cyc - lastStep, 2);
                end
                streamPos++;
                if (streamPos % BPI == 0) sinceLast = 0;
                else if (sinceLast >= 0) sinceLast++;
            end else if (sinceLast >= 0) begin
                sinceLast++;
            end

            img = (streamPos == 0) ? 0 : (streamPos - 1) / BPI;
            lab = labelOf(img);
            if (sinceLast == LAT && img < IC) begin
                dut_index = wrongMask[img] ? wrongIdx(img) : lab;
                dut_value = scoreOf(img);
            end else begin
                dut_index = lab ^ 4'h8;
                dut_value = 8'($urandom);
            end

            case (pacing)
                0:       step = 1'b1;
                1:       step = ($urandom_range(0, 3) == 0);
                default: step = (cyc % 20 == 19);
            endcase
            if (step) lastStep = cyc;
            start = midStart && (cyc == 3);

            if (cyc == resetAt) begin
                rst = 1'b1;
                @(negedge clk);
                checkResetState();
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) return;

        checkOutput("done", int'(done), 1);
        checkOutput("bytes", streamPos, nExp * BPI);
        checkOutput("pass", int'(pass_count), passExp);
        checkOutput("fail", int'(fail_count), failExp);
        checkOutput("failed", int'(failed), int'(failedExp));
        checkOutput("first_fail", int'(first_fail), firstExp);
        checkOutput("res_index", int'(result_index),
                    int'(wrongMask[nExp-1] ? wrongIdx(nExp - 1) : labelOf(nExp - 1)));
        checkOutput("res_value", int'(result_value), int'(scoreOf(nExp - 1)));
        checkOutput("exp_final", int'(expected), (nExp - 1) % NC);
        checkOutput("busy_end", int'(busy), 0);

        step = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("hold_done", int'(done), 1);
        checkOutput("hold_valid", int'(dut_valid), 0);
        checkOutput("hold_pass", int'(pass_count), passExp);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        step = 1'b0;
        stop_on_fail = 1'b0;
        dut_index = '0;
        dut_value = '0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;

        $display("[TB] ideal core, full speed");
        applyStimulus(1'b0, 0, 12'h000, 1'b0, -1);
        $display("[TB] wrong on image 1, run all");
        applyStimulus(1'b0, 0, 12'h002, 1'b0, -1);
        $display("[TB] wrong on image 1, stop on fail");
        applyStimulus(1'b1, 0, 12'h002, 1'b0, -1);
        $display("[TB] step pulsed every 20 cycles");
        applyStimulus(1'b0, 2, 12'h000, 1'b0, -1);
        $display("[TB] reset mid-feed");
        applyStimulus(1'b0, 0, 12'h001, 1'b1, 10);
        $display("[TB] restart with start pulse while busy");
        applyStimulus(1'b0, 0, 12'h000, 1'b1, -1);
        for (int r = 0; r < 6; r++) begin
            logic [IC-1:0] mask;
            mask = IC'($urandom & $urandom & $urandom);
            $display("[TB] random run %0d mask %h", r, mask);
            applyStimulus(1'($urandom_range(0, 1)), 1, mask, 1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
